// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART types and constants shared by the transmit and receive paths
package uart_pkg;

    localparam int UART_DATA_W               = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 5208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - bit-period counter; o_bit_end marks the last cycle of each bit
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_bit_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_bit_end = (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter; define UART_TX_PARITY_EN to add a parity bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int               IDX_W    = $clog2(UART_DATA_W);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_W - 1);

    uart_tx_state_t         r_state;
    logic [UART_DATA_W-1:0] r_shreg;
    logic [IDX_W-1:0]       r_bit_idx;
    logic                   r_stop_idx;
    logic                   r_tx;
    logic                   r_ready;
    logic                   r_done;

    logic [CNT_W-1:0]       w_count;
    logic                   w_bit_end;
    logic                   w_pre_end;
    logic                   w_last_stop;
    logic                   w_hs;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic r_parity;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    uart_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state == IDLE),
        .o_count   (w_count),
        .o_bit_end (w_bit_end)
    );

    assign w_pre_end   = (w_count == PRE_LAST);
    assign w_last_stop = (STOP_BITS == 2) ? r_stop_idx : 1'b1;
    assign w_hs        = tx_valid & r_ready;

    // Ready rises one cycle early so a handshake on the final stop cycle
    // launches the next start bit with no idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_hs) begin
                r_state  <= START;
                r_shreg  <= tx_data;
                r_tx     <= 1'b0;
                r_ready  <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_parity <= (^tx_data) ^ PAR_ODD;
`endif
            end else begin
                case (r_state)
                    START: begin
                        if (w_bit_end) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                            r_tx      <= r_shreg[0];
                        end
                    end
                    DATA: begin
                        if (w_bit_end) begin
                            if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                                r_state    <= PARITY;
                                r_tx       <= r_parity;
`else
                                r_state    <= STOP;
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                                r_shreg   <= r_shreg >> 1;
                                r_tx      <= r_shreg[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (w_bit_end) begin
                            r_state    <= STOP;
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                        end
                    end
`endif
                    STOP: begin
                        if (w_pre_end && w_last_stop) begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                        end
                        if (w_bit_end) begin
                            if (w_last_stop) begin
                                r_state <= IDLE;
                            end else begin
                                r_stop_idx <= 1'b1;
                            end
                        end
                    end
                    IDLE: begin
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                        r_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = ~r_ready;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int CPB_L = 5208;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int F1 = (10 + PAR_EN) * CPB;
    localparam int FL = 11 + PAR_EN;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx;
    logic [7:0] l_tx_data;
    logic       l_tx_valid;
    logic       l_tx_ready, l_tx_busy, l_tx_done, l_tx;

    int errors = 0;
    int checks = 0;
    logic [3:0] c_obs [1:256];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
    );

    uart_tx #(.CLKS_PER_BIT(CPB_L), .STOP_BITS(2), .PARITY_ODD(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .tx_data(l_tx_data), .tx_valid(l_tx_valid),
        .tx_ready(l_tx_ready), .tx_busy(l_tx_busy), .tx_done(l_tx_done), .tx(l_tx)
    );

    // Line level during frame bit k: start, data LSB first, optional parity, then idle/stop high.
    function automatic logic exp_bit(input logic [7:0] d, input int k, input logic odd);
        if (k == 0) return 1'b0;
        if (k >= 1 && k <= 8) return d[k-1];
        if (PAR_EN == 1 && k == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    // {tx, done, ready, busy} expected n cycles after the handshake edge.
    function automatic logic [3:0] exp_obs(input logic [7:0] d, input int n);
        return {exp_bit(d, (n - 1) / CPB, 1'b0), (n == F1), (n >= F1), (n < F1)};
    endfunction

    task automatic handshake(input logic [7:0] d);
        int w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_wait ready=%b want 1", tx_ready);
        end
        @(posedge clk);
    endtask

    task automatic capture(input int n, input int valid_off, input logic [7:0] data1,
                           input int g_on, input int g_off, input logic [7:0] g_data);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            c_obs[i] = {tx, tx_done, tx_ready, tx_busy};
            if (i == 1) tx_data = data1;
            if (i == valid_off) tx_valid = 1'b0;
            if (i == g_on) begin
                tx_valid = 1'b1;
                tx_data  = g_data;
            end
            if (i == g_off) tx_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        tx_valid = 1'b0; tx_data = 8'h00; l_tx_valid = 1'b0; l_tx_data = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, tx_done, tx_ready, tx_busy} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_state got=%b want=1010", {tx, tx_done, tx_ready, tx_busy});
        end
        checks++;
        if ({l_tx, l_tx_done, l_tx_ready, l_tx_busy} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_state_long got=%b want=1010", {l_tx, l_tx_done, l_tx_ready, l_tx_busy});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, tx_done, tx_ready, tx_busy} !== 4'b1010) begin
            errors++;
            $display("FAIL idle_after_reset got=%b want=1010", {tx, tx_done, tx_ready, tx_busy});
        end
    endtask

    task automatic test_single_55;
        handshake(8'h55);
        capture(F1 + 2, 1, 8'($urandom), 0, 0, 8'h00);
        for (int i = 1; i <= F1 + 2; i++) begin
            checks++;
            if (c_obs[i] !== exp_obs(8'h55, i)) begin
                errors++;
                $display("FAIL single_55 cycle=%0d got=%b want=%b", i, c_obs[i], exp_obs(8'h55, i));
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake(d);
            capture(F1 + 2, 1, 8'($urandom), 0, 0, 8'h00);
            for (int i = 1; i <= F1 + 2; i++) begin
                checks++;
                if (c_obs[i] !== exp_obs(d, i)) begin
                    errors++;
                    $display("FAIL random_%02h cycle=%0d got=%b want=%b", d, i, c_obs[i], exp_obs(d, i));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] want;
        handshake(8'hA3);
        capture(2 * F1 + 2, F1 + 1, 8'h0F, 0, 0, 8'h00);
        for (int i = 1; i <= 2 * F1 + 2; i++) begin
            want = (i <= F1) ? exp_obs(8'hA3, i) : exp_obs(8'h0F, i - F1);
            checks++;
            if (c_obs[i] !== want) begin
                errors++;
                $display("FAIL back_to_back cycle=%0d got=%b want=%b", i, c_obs[i], want);
            end
        end
    endtask

    task automatic test_ignore_midframe;
        handshake(8'h12);
        capture(F1 + 2, 1, 8'h12, 15, 19, 8'hFF);
        for (int i = 1; i <= F1 + 2; i++) begin
            checks++;
            if (c_obs[i] !== exp_obs(8'h12, i)) begin
                errors++;
                $display("FAIL ignore_midframe cycle=%0d got=%b want=%b", i, c_obs[i], exp_obs(8'h12, i));
            end
        end
    endtask

    task automatic test_reset_midframe;
        handshake(8'hC3);
        capture(17, 1, 8'h5A, 0, 0, 8'h00);
        for (int i = 1; i <= 17; i++) begin
            checks++;
            if (c_obs[i] !== exp_obs(8'hC3, i)) begin
                errors++;
                $display("FAIL pre_reset_c3 cycle=%0d got=%b want=%b", i, c_obs[i], exp_obs(8'hC3, i));
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, tx_done, tx_ready, tx_busy} !== 4'b1010) begin
            errors++;
            $display("FAIL midframe_reset got=%b want=1010", {tx, tx_done, tx_ready, tx_busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        handshake(8'h81);
        capture(F1 + 2, 1, 8'($urandom), 0, 0, 8'h00);
        for (int i = 1; i <= F1 + 2; i++) begin
            checks++;
            if (c_obs[i] !== exp_obs(8'h81, i)) begin
                errors++;
                $display("FAIL post_reset_81 cycle=%0d got=%b want=%b", i, c_obs[i], exp_obs(8'h81, i));
            end
        end
    endtask

    task automatic test_parity_byte;
        handshake(8'h07);
        capture(F1 + 2, 1, 8'($urandom), 0, 0, 8'h00);
        for (int i = 1; i <= F1 + 2; i++) begin
            checks++;
            if (c_obs[i] !== exp_obs(8'h07, i)) begin
                errors++;
                $display("FAIL byte_07 cycle=%0d got=%b want=%b", i, c_obs[i], exp_obs(8'h07, i));
            end
        end
`ifdef UART_TX_PARITY_EN
        checks++;
        if (c_obs[9 * CPB + 1][3] !== 1'b1) begin
            errors++;
            $display("FAIL even_parity_07 got=%b want=1", c_obs[9 * CPB + 1][3]);
        end
`endif
    endtask

    task automatic test_long_two_stop;
        int good [16];
        int low     = 0;
        int done_at = -1;
        int done_n  = 0;
        int total   = FL * CPB_L;
        int k;
        for (int j = 0; j < 16; j++) good[j] = 0;
        l_tx_data  = 8'h00;
        l_tx_valid = 1'b1;
        checks++;
        if (l_tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL long_ready got=%b want=1", l_tx_ready);
        end
        @(posedge clk);
        for (int n = 1; n <= total + 2; n++) begin
            @(negedge clk);
            if (n == 1) l_tx_valid = 1'b0;
            k = (n - 1) / CPB_L;
            if (k < 16 && l_tx === exp_bit(8'h00, k, 1'b1)) good[k]++;
            if (l_tx === 1'b0) low++;
            if (l_tx_done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = n;
            end
        end
        for (int b = 0; b < FL; b++) begin
            checks++;
            if (good[b] !== CPB_L) begin
                errors++;
                $display("FAIL long_bit%0d correct_cycles=%0d want=%0d", b, good[b], CPB_L);
            end
        end
        checks++;
        if (low !== 9 * CPB_L) begin
            errors++;
            $display("FAIL long_low_run got=%0d want=%0d", low, 9 * CPB_L);
        end
        checks++;
        if (done_at !== total || done_n !== 1) begin
            errors++;
            $display("FAIL long_done at=%0d count=%0d want at=%0d count=1", done_at, done_n, total);
        end
    endtask

    initial begin
        test_reset;
        test_single_55;
        test_random;
        test_back_to_back;
        test_ignore_midframe;
        test_reset_midframe;
        test_parity_byte;
        test_long_two_stop;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
